// File: rtl/mem_wait_slave_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_wait_slave_pkg                                        |
// | Purpose  : Shared encodings for the wait-state memory responder:     |
// |            bus direction codes, byte-enable width, FSM state codes   |
// |            and the wait-counter width.                               |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package mem_wait_slave_pkg;

  // Bus geometry of the mem_ctrl interface
  localparam int DATA_WIDTH_GPR = 32;
  localparam int WORD_ADDR_BUS  = 30;
  localparam int MEM_BE_WIDTH   = DATA_WIDTH_GPR / 8;

  // memory_rw encodings
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Wait counter must hold the largest legal WAIT_CYCLES (15)
  localparam int MWS_CNT_W = 4;

  typedef enum logic [1:0] {
    MWS_IDLE = 2'b00,
    MWS_BUSY = 2'b01,
    MWS_ACK  = 2'b10
  } mws_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_wait_slave_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_wait_array                                            |
// | Purpose  : 2^DEPTH_LOG2 x DATA_W storage for mem_wait_slave with a   |
// |            synchronous byte-enabled write port and a registered      |
// |            read port. Storage has no reset.                          |
// | Ports    : clk        - clock                                        |
// |            wr_en_i    - commit enabled bytes of wr_data_i            |
// |            wr_addr_i  - write word address                           |
// |            wr_be_i    - byte enables, bit i -> bits [8i+7:8i]        |
// |            wr_data_i  - write data                                   |
// |            rd_en_i    - load the read register                       |
// |            rd_clr_i   - when loading, load zero instead of a word    |
// |            rd_addr_i  - read word address                            |
// |            rd_data_o  - registered read data                         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mem_wait_array #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                    clk,
  input  logic                    wr_en_i,
  input  logic [DEPTH_LOG2-1:0]   wr_addr_i,
  input  logic [DATA_W/8-1:0]     wr_be_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  input  logic                    rd_en_i,
  input  logic                    rd_clr_i,
  input  logic [DEPTH_LOG2-1:0]   rd_addr_i,
  output logic [DATA_W-1:0]       rd_data_o
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_be_i[b]) begin
          mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

  // The clear path lets the owner force a known zero (reset, out-of-range
  // reads) without putting a reset on the storage itself.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= rd_clr_i ? '0 : mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/mem_wait_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_wait_slave                                            |
// | Purpose  : Word-addressed data-memory responder for the mem_ctrl bus |
// |            with WAIT_CYCLES wait states, a four-phase memory_rdy_    |
// |            handshake, byte-enabled writes and out-of-range flagging. |
// | Ports    : clk            - clock, rising edge                       |
// |            rst_           - synchronous reset, active low            |
// |            memory_addr    - word address                             |
// |            memory_as_     - address strobe, active low               |
// |            memory_rw      - READ (1) / WRITE (0)                     |
// |            memory_be      - write byte enables                       |
// |            memory_wr_data - write data                               |
// |            memory_rd_data - read data, valid while memory_rdy_ low   |
// |            memory_rdy_    - ready, active low                        |
// |            memory_err     - address out of range, valid in ACK       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mem_wait_slave
  import mem_wait_slave_pkg::*;
#(
  parameter int DATA_W      = DATA_WIDTH_GPR,
  parameter int ADDR_W      = WORD_ADDR_BUS,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [ADDR_W-1:0]     memory_addr,
  input  logic                  memory_as_,
  input  logic                  memory_rw,
  input  logic [DATA_W/8-1:0]   memory_be,
  input  logic [DATA_W-1:0]     memory_wr_data,
  output logic [DATA_W-1:0]     memory_rd_data,
  output logic                  memory_rdy_,
  output logic                  memory_err
);

  localparam logic [MWS_CNT_W-1:0] c_WAIT = MWS_CNT_W'(WAIT_CYCLES);

  mws_state_e               state_q, state_d;
  logic [MWS_CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic                     rw_q, rw_d;
  logic [DATA_W/8-1:0]      be_q, be_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic                     rdy_q, rdy_d;
  logic                     err_q, err_d;

  logic [ADDR_W-1:0]        w_sel_addr;
  logic                     w_sel_rw;
  logic [DATA_W/8-1:0]      w_sel_be;
  logic [DATA_W-1:0]        w_sel_wdata;
  logic                     w_oor;
  logic                     w_enter_ack;
  logic                     w_wr_en;
  logic                     w_rd_en;
  logic                     w_rd_clr;
  logic [DATA_W-1:0]        w_rd_data;

  // With zero wait states the ACK entry edge is the acceptance edge, so the
  // request has not been latched yet; use the live bus fields in IDLE and
  // the latched copy everywhere else.
  assign w_sel_addr  = (state_q == MWS_IDLE) ? memory_addr    : addr_q;
  assign w_sel_rw    = (state_q == MWS_IDLE) ? memory_rw      : rw_q;
  assign w_sel_be    = (state_q == MWS_IDLE) ? memory_be      : be_q;
  assign w_sel_wdata = (state_q == MWS_IDLE) ? memory_wr_data : wdata_q;

  generate
    if (DEPTH_LOG2 < ADDR_W) begin : g_range_chk
      assign w_oor = |w_sel_addr[ADDR_W-1:DEPTH_LOG2];
    end else begin : g_range_full
      assign w_oor = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Next-state and output-register logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdy_d   = rdy_q;
    err_d   = err_q;

    case (state_q)
      MWS_IDLE: begin
        if (!memory_as_) begin
          addr_d  = memory_addr;
          rw_d    = memory_rw;
          be_d    = memory_be;
          wdata_d = memory_wr_data;
          cnt_d   = c_WAIT;
          state_d = (WAIT_CYCLES == 0) ? MWS_ACK : MWS_BUSY;
        end
      end

      MWS_BUSY: begin
        if (memory_as_) begin
          // Initiator withdrew the request: drop it without side effects
          state_d = MWS_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= MWS_CNT_W'(1)) begin
          state_d = MWS_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - MWS_CNT_W'(1);
        end
      end

      MWS_ACK: begin
        if (memory_as_) begin
          state_d = MWS_IDLE;
          rdy_d   = 1'b1;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = MWS_IDLE;
        cnt_d   = '0;
        rdy_d   = 1'b1;
        err_d   = 1'b0;
      end
    endcase

    if (w_enter_ack) begin
      rdy_d = 1'b0;
      err_d = w_oor;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= MWS_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= READ;
      be_q    <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Storage side effects happen only on the edge that enters ACK, so a
  // write is committed exactly once however long the initiator holds as_.
  // rst_ gates both ports: a reset landing on that edge abandons the write.
  // ---------------------------------------------------------------------
  assign w_enter_ack = (state_d == MWS_ACK) && (state_q != MWS_ACK) && rst_;
  assign w_wr_en     = w_enter_ack && (w_sel_rw == WRITE) && !w_oor;
  assign w_rd_en     = (w_enter_ack && ((w_sel_rw == READ) || w_oor)) || !rst_;
  assign w_rd_clr    = !rst_ || w_oor;

  mem_wait_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk       (clk),
    .wr_en_i   (w_wr_en),
    .wr_addr_i (w_sel_addr[DEPTH_LOG2-1:0]),
    .wr_be_i   (w_sel_be),
    .wr_data_i (w_sel_wdata),
    .rd_en_i   (w_rd_en),
    .rd_clr_i  (w_rd_clr),
    .rd_addr_i (w_sel_addr[DEPTH_LOG2-1:0]),
    .rd_data_o (w_rd_data)
  );

  assign memory_rd_data = w_rd_data;
  assign memory_rdy_    = rdy_q;
  assign memory_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wait_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mem_wait_slave                                         |
// | Purpose  : Self-checking bench for mem_wait_slave. Instance dut uses |
// |            WAIT_CYCLES=2, instance dut0 uses WAIT_CYCLES=0. Expected |
// |            read results are queued when a read is issued and popped  |
// |            when memory_rdy_ falls.                                   |
// | Ports    : none                                                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_mem_wait_slave;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_;
  logic [29:0] mem_addr;
  logic        mem_as_;
  logic        mem_as0_;
  logic        mem_rw;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] rd_data, rd_data0;
  logic        rdy_, rdy0_;
  logic        err, err0;

  bit          use0;
  logic        m_rdy_;
  logic        m_err;
  logic [31:0] m_rd_data;

  int          vectors;
  int          miscompares;
  exp_t        sb[$];
  logic [31:0] model [2][256];

  assign m_rdy_    = use0 ? rdy0_    : rdy_;
  assign m_err     = use0 ? err0     : err;
  assign m_rd_data = use0 ? rd_data0 : rd_data;

  mem_wait_slave #(
    .DATA_W(32), .ADDR_W(30), .DEPTH_LOG2(8), .WAIT_CYCLES(2)
  ) dut (
    .clk(clk), .rst_(rst_), .memory_addr(mem_addr), .memory_as_(mem_as_),
    .memory_rw(mem_rw), .memory_be(mem_be), .memory_wr_data(mem_wdata),
    .memory_rd_data(rd_data), .memory_rdy_(rdy_), .memory_err(err)
  );

  mem_wait_slave #(
    .DATA_W(32), .ADDR_W(30), .DEPTH_LOG2(8), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst_(rst_), .memory_addr(mem_addr), .memory_as_(mem_as0_),
    .memory_rw(mem_rw), .memory_be(mem_be), .memory_wr_data(mem_wdata),
    .memory_rd_data(rd_data0), .memory_rdy_(rdy0_), .memory_err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete four-phase access. Caller must be positioned just after a
  // rising edge; as_ is driven low immediately (minimum IDLE gap).
  task automatic access(input bit sel, input logic rw, input logic [29:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input int hold, input string tag);
    int   lat;
    int   exp_lat;
    bit   oor;
    exp_t e;
    logic [7:0] idx;
    use0    = sel;
    oor     = (addr >= 30'd256);
    idx     = addr[7:0];
    exp_lat = sel ? 1 : 3;
    if (rw == RD) begin
      e.data = oor ? 32'h0 : model[sel][idx];
      e.err  = oor;
      sb.push_back(e);
    end
    mem_addr  = addr;
    mem_rw    = rw;
    mem_be    = be;
    mem_wdata = wdata;
    if (sel) mem_as0_ = 1'b0; else mem_as_ = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (m_rdy_ === 1'b1 && lat < 40);

    vectors++;
    if (m_rdy_ !== 1'b0) begin
      miscompares++;
      $display("FAIL %s timeout: rdy_=%b after %0d edges, required 0", tag, m_rdy_, lat);
      if (rw == RD) void'(sb.pop_front());
      mem_as_ = 1'b1; mem_as0_ = 1'b1;
      @(posedge clk); #1;
      return;
    end
    if (lat != exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d edges, required %0d", tag, lat, exp_lat);
    end
    vectors++;
    if (m_err !== oor) begin
      miscompares++;
      $display("FAIL %s err: got %b, required %b", tag, m_err, oor);
    end
    if (rw == RD) begin
      e = sb.pop_front();
      vectors++;
      if (m_rd_data !== e.data) begin
        miscompares++;
        $display("FAIL %s rd_data: got %h, required %h", tag, m_rd_data, e.data);
      end
    end else if (!oor) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model[sel][idx][8*b +: 8] = wdata[8*b +: 8];
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      vectors++;
      if (m_rdy_ !== 1'b0) begin
        miscompares++;
        $display("FAIL %s hold%0d: rdy_=%b, required 0", tag, h, m_rdy_);
      end
    end
    if (sel) mem_as0_ = 1'b1; else mem_as_ = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (m_rdy_ !== 1'b1) begin
      miscompares++;
      $display("FAIL %s release: rdy_=%b, required 1", tag, m_rdy_);
    end
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors += 6;
    if (rdy_ !== 1'b1)      begin miscompares++; $display("FAIL reset rdy_: got %b, required 1", rdy_); end
    if (err !== 1'b0)       begin miscompares++; $display("FAIL reset err: got %b, required 0", err); end
    if (rd_data !== 32'h0)  begin miscompares++; $display("FAIL reset rd_data: got %h, required 0", rd_data); end
    if (rdy0_ !== 1'b1)     begin miscompares++; $display("FAIL reset0 rdy_: got %b, required 1", rdy0_); end
    if (err0 !== 1'b0)      begin miscompares++; $display("FAIL reset0 err: got %b, required 0", err0); end
    if (rd_data0 !== 32'h0) begin miscompares++; $display("FAIL reset0 rd_data: got %h, required 0", rd_data0); end
    rst_ = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    access(0, WR, 30'd4, 4'hF, 32'h01234567, 0, "wr4");
    access(0, RD, 30'd4, 4'hF, 32'h0,        0, "rd4");
  endtask

  task automatic test_byte_enables();
    access(0, WR, 30'd8, 4'hF,    32'hFFFFFFFF, 0, "be_full");
    access(0, WR, 30'd8, 4'b0010, 32'h0000AA00, 0, "be_lane1");
    access(0, RD, 30'd8, 4'hF,    32'h0,        0, "be_rd");
    vectors++;
    if (rd_data !== 32'hFFFFAAFF) begin
      miscompares++;
      $display("FAIL be_merge: got %h, required ffffaaff", rd_data);
    end
    access(0, WR, 30'd8, 4'b0000, 32'h12345678, 0, "be_none");
    access(0, RD, 30'd8, 4'hF,    32'h0,        0, "be_none_rd");
  endtask

  task automatic test_back_to_back();
    access(0, RD, 30'd4, 4'hF, 32'h0, 0, "b2b_a");
    access(0, RD, 30'd8, 4'hF, 32'h0, 0, "b2b_b");
    access(0, RD, 30'd4, 4'hF, 32'h0, 0, "b2b_c");
  endtask

  task automatic test_abort();
    access(0, WR, 30'd12, 4'hF, 32'h11111111, 0, "abort_pre");
    use0      = 1'b0;
    mem_addr  = 30'd12;
    mem_rw    = WR;
    mem_be    = 4'hF;
    mem_wdata = 32'hDEADBEEF;
    mem_as_   = 1'b0;
    @(posedge clk); #1;
    mem_as_   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (rdy_ !== 1'b1) begin
        miscompares++;
        $display("FAIL abort rdy_%0d: got %b, required 1", i, rdy_);
      end
    end
    access(0, RD, 30'd12, 4'hF, 32'h0, 0, "abort_rd");
  endtask

  task automatic test_out_of_range();
    access(0, RD, 30'd256, 4'hF, 32'h0,        0, "oor_rd256");
    access(0, WR, 30'd44,  4'hF, 32'h44444444, 0, "oor_pre44");
    access(0, WR, 30'd300, 4'hF, 32'h99999999, 0, "oor_wr300");
    access(0, RD, 30'd44,  4'hF, 32'h0,        0, "oor_rd44");
  endtask

  task automatic test_four_phase_hold();
    access(0, WR, 30'd30, 4'hF, 32'h5A5A5A5A, 3, "hold_wr");
    access(0, RD, 30'd30, 4'hF, 32'h0,        3, "hold_rd");
  endtask

  task automatic test_zero_wait();
    access(1, WR, 30'd5,   4'hF,    32'hCAFEF00D, 0, "zw_wr");
    access(1, WR, 30'd5,   4'b1000, 32'h11000000, 0, "zw_wr_be");
    access(1, RD, 30'd5,   4'hF,    32'h0,        0, "zw_rd");
    access(1, RD, 30'd511, 4'hF,    32'h0,        2, "zw_oor");
    use0 = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    access(0, WR, 30'd20, 4'hF, 32'h22222222, 0, "rst_pre");
    access(0, RD, 30'd20, 4'hF, 32'h0,        0, "rst_pre_rd");
    use0      = 1'b0;
    mem_addr  = 30'd20;
    mem_rw    = WR;
    mem_be    = 4'hF;
    mem_wdata = 32'h33333333;
    mem_as_   = 1'b0;
    @(posedge clk); #1;   // accepted, BUSY
    @(posedge clk); #1;   // next edge would enter ACK
    rst_ = 1'b0;
    @(posedge clk); #1;
    vectors += 3;
    if (rdy_ !== 1'b1)     begin miscompares++; $display("FAIL rst_mid rdy_: got %b, required 1", rdy_); end
    if (err !== 1'b0)      begin miscompares++; $display("FAIL rst_mid err: got %b, required 0", err); end
    if (rd_data !== 32'h0) begin miscompares++; $display("FAIL rst_mid rd_data: got %h, required 0", rd_data); end
    rst_    = 1'b1;
    mem_as_ = 1'b1;
    @(posedge clk); #1;
    access(0, RD, 30'd20, 4'hF, 32'h0, 0, "rst_post_rd");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    use0        = 1'b0;
    rst_        = 1'b0;
    mem_addr    = '0;
    mem_as_     = 1'b1;
    mem_as0_    = 1'b1;
    mem_rw      = RD;
    mem_be      = '0;
    mem_wdata   = '0;

    test_reset();
    test_write_read();
    test_byte_enables();
    test_back_to_back();
    test_abort();
    test_out_of_range();
    test_four_phase_hold();
    test_zero_wait();
    test_reset_mid_busy();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_wait_slave.md
# mem_wait_slave

Word-addressed data-memory responder for the `mem_ctrl` bus. It accepts `memory_as_`-qualified read/write requests, inserts a configurable number of wait states, and completes each access with a four-phase `memory_rdy_` handshake. Byte-enabled writes and an out-of-range error flag are supported. It replaces the zero-wait `memory` model wherever the core must tolerate slow memory.

## Interface
- `DATA_W`, 32, data width; fixed to `DATA_WIDTH_GPR`
- `ADDR_W`, 30, word-address width, matching `WORD_ADDR_BUS`
- `DEPTH_LOG2`, 8, log2 of the number of implemented words (256)
- `WAIT_CYCLES`, 2, wait states inserted before ready; legal range 0..15

- `clk`  in  1  clock; all logic on the rising edge
- `rst_`  in  1  reset, synchronous, active-low
- `memory_addr`  in  ADDR_W  word address
- `memory_as_`  in  1  address strobe, active-low; initiator holds it low until `memory_rdy_` is low
- `memory_rw`  in  1  `READ` (1) or `WRITE` (0)
- `memory_be`  in  DATA_W/8  byte enables for writes; bit i selects bits [8i+7:8i]
- `memory_wr_data`  in  DATA_W  write data
- `memory_rd_data`  out  DATA_W  read data; valid while `memory_rdy_` is low
- `memory_rdy_`  out  1  ready, active-low
- `memory_err`  out  1  address out of range; valid while `memory_rdy_` is low

## Operation
- FSM states: IDLE, BUSY, ACK.
- **IDLE**
  - When `memory_as_` is sampled low, latch addr, rw, be and wr_data.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to BUSY, or straight to ACK when `WAIT_CYCLES` = 0.
- **BUSY**
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to ACK on the next edge.
  - If `memory_as_` is sampled high (abort), return to IDLE. No write is performed and `memory_rdy_` is not asserted.
- **ACK entry edge**
  - A write commits the enabled bytes exactly once.
  - A read registers the word into `memory_rd_data`.
- **In ACK**
  - `memory_rdy_` stays low while `memory_as_` is low.
  - When `memory_as_` is sampled high, go to IDLE. `memory_rdy_` returns high that same edge.
- **Out-of-range** (`memory_addr` >= 2^DEPTH_LOG2): no write, `memory_rd_data` = 0, `memory_err` = 1 for the ACK duration.
- **Write with `memory_be` = 0:** completes the handshake and changes no bytes.
- Latched fields are used for the whole access. Input changes after acceptance are ignored.
- Storage is not cleared by reset; contents are undefined until written.

## Timing
- **Reset values:** state IDLE, `memory_rdy_` = 1, `memory_rd_data` = 0, `memory_err` = 0, counter = 0.
- Reset asserted mid-access abandons the access. A write not yet at its ACK entry edge is never committed.
- **Latency:** `memory_rdy_` goes low `WAIT_CYCLES`+1 edges after the edge that samples `memory_as_` low.
- **Minimum access:** `WAIT_CYCLES`+2 cycles, including one IDLE cycle between back-to-back accesses.
- Read data reflects a write from an earlier completed access. There is no forwarding within an access.
- `memory_rd_data` holds its last value outside ACK; the initiator must not use it.

## Structure
- Add to `define.v`:
  - `READ`/`WRITE` encodings
  - byte-enable width `MEM_BE_WIDTH`
  - state encodings `MWS_IDLE`, `MWS_BUSY`, `MWS_ACK` (2 bits)
- One sub-module, `mem_wait_array`:
  - 2^DEPTH_LOG2 × DATA_W register array
  - synchronous byte-enabled write port, registered read port
  - no reset
- `mem_wait_slave` holds the FSM, wait counter, request latches, range check and output registers.

## Test plan
- **Write/read, `WAIT_CYCLES`=2:**
  - write 0x01234567 to address 4 with be=4'hF, then read address 4
  - `memory_rdy_` low on the 3rd edge after the `as_` sample; rd_data=0x01234567, err=0
- **Byte enables:**
  - write 0xFFFFFFFF to address 8, then write 0x0000AA00 with be=4'b0010, then read
  - read returns 0xFFFFAAFF
- **Abort:**
  - start a write of 0xDEADBEEF to address 12 with prior content 0x11111111; raise `as_` in BUSY
  - no `rdy_`; a later read returns 0x11111111
- **Out-of-range:**
  - read address 256 → err=1, rd_data=0
  - write to address 300, then read address 300 & 255 → that content is unchanged
- **Four-phase hold:**
  - hold `as_` low 3 cycles after `rdy_` falls → `rdy_` stays low 3 cycles and the write commits once
  - `WAIT_CYCLES`=0 → `rdy_` falls 1 edge after the `as_` sample
- **Reset mid-BUSY:**
  - assert `rst_`=0 during a write → outputs return to reset values next edge; the target word is unchanged
